// File: rtl/dsp_c_accum.sv
// dsp_c_accum: registered 48-bit C-path accumulator with carry, signed overflow and pattern-detect flags
module dsp_c_accum #(
   parameter int          PIPE_IN  = 0,
   parameter int          SATURATE = 0,
   parameter logic [47:0] PATTERN  = 48'h0,
   parameter logic [47:0] MASK     = 48'h0
) (
   input  logic        CLK_creg,
   input  logic        RSTC,
   input  logic [47:0] C_DATA,
   input  logic        IN_VALID,
   input  logic [1:0]  OPMODE,
   input  logic        CARRYIN,
   input  logic        CEP,
   input  logic        CLRP,
   output logic [47:0] P,
   output logic        OUT_VALID,
   output logic        CARRYOUT,
   output logic        OVERFLOW,
   output logic        UNDERFLOW,
   output logic        OVF_STICKY,
   output logic        PATTERNDETECT
);
   localparam logic [47:0] P_MAX  = 48'h7FFF_FFFF_FFFF;
   localparam logic [47:0] P_MIN  = 48'h8000_0000_0000;
   localparam logic        PD_RST = ((PATTERN & ~MASK) == 48'h0);
   logic [47:0] s_c;
   logic [1:0]  s_op;
   logic        s_ci;
   logic        s_v;
   logic [49:0] p_x;
   logic [49:0] c_x;
   logic [49:0] r;
   logic [48:0] u_sum;
   logic [48:0] u_dif;
   logic        ar;
   logic        ovf;
   logic        unf;
   logic        cy;
   logic [47:0] p_nxt;
   logic        pd_nxt;
   generate
      if (PIPE_IN == 1) begin : g_pipe
         // optional input stage; clear or reset drops any operation waiting here
         always_ff @(posedge CLK_creg or negedge RSTC) begin
            if (!RSTC) begin
               s_c  <= 48'h0;
               s_op <= 2'b00;
               s_ci <= 1'b0;
               s_v  <= 1'b0;
            end else if (CLRP) begin
               s_c  <= 48'h0;
               s_op <= 2'b00;
               s_ci <= 1'b0;
               s_v  <= 1'b0;
            end else if (CEP) begin
               s_c  <= C_DATA;
               s_op <= OPMODE;
               s_ci <= CARRYIN;
               s_v  <= IN_VALID;
            end
         end
      end else if (PIPE_IN == 0) begin : g_direct
         assign s_c  = C_DATA;
         assign s_op = OPMODE;
         assign s_ci = CARRYIN;
         assign s_v  = IN_VALID;
      end else begin : g_bad
         $fatal(1, "dsp_c_accum: PIPE_IN must be 0 or 1");
      end
   endgenerate
   // ALU: 50-bit signed result for range flags, 49-bit unsigned for carry/borrow
   always_comb begin
      p_x    = {{2{P[47]}}, P};
      c_x    = {{2{s_c[47]}}, s_c};
      r      = s_op[0] ? p_x - c_x - {49'd0, s_ci} : p_x + c_x + {49'd0, s_ci};
      u_sum  = {1'b0, P} + {1'b0, s_c} + {48'd0, s_ci};
      u_dif  = {1'b0, P} - {1'b0, s_c} - {48'd0, s_ci};
      ar     = s_op[1];
      ovf    = ar & ~r[49] & (r[48] | r[47]);
      unf    = ar & r[49] & ~(r[48] & r[47]);
      cy     = ar & (s_op[0] ? u_dif[48] : u_sum[48]);
      p_nxt  = !ar ? (s_op[0] ? s_c : 48'h0) :
               (SATURATE != 0 && ovf) ? P_MAX :
               (SATURATE != 0 && unf) ? P_MIN : r[47:0];
      pd_nxt = ((p_nxt ^ PATTERN) & ~MASK) == 48'h0;
   end
   // result register: loads on a valid enabled cycle, otherwise holds P and flags
   always_ff @(posedge CLK_creg or negedge RSTC) begin
      if (!RSTC) begin
         P             <= 48'h0;
         OUT_VALID     <= 1'b0;
         CARRYOUT      <= 1'b0;
         OVERFLOW      <= 1'b0;
         UNDERFLOW     <= 1'b0;
         OVF_STICKY    <= 1'b0;
         PATTERNDETECT <= PD_RST;
      end else if (CLRP) begin
         P             <= 48'h0;
         OUT_VALID     <= 1'b0;
         CARRYOUT      <= 1'b0;
         OVERFLOW      <= 1'b0;
         UNDERFLOW     <= 1'b0;
         OVF_STICKY    <= 1'b0;
         PATTERNDETECT <= PD_RST;
      end else if (CEP) begin
         OUT_VALID <= s_v;
         if (s_v) begin
            P             <= p_nxt;
            CARRYOUT      <= cy;
            OVERFLOW      <= ovf;
            UNDERFLOW     <= unf;
            OVF_STICKY    <= OVF_STICKY | ovf | unf;
            PATTERNDETECT <= pd_nxt;
         end
      end
   end
endmodule
